// File: rtl/debug_frame_receiver.sv
// ---------------------------------------------------------------------------
// debug_frame_receiver
//
// Serial debug-frame receiver. A frame starts on data_start. DATA_WIDTH bits
// are then shifted in from sin, one per clock. Each completed word is pushed
// into a small show-ahead FIFO, which the consumer drains with a valid/ready
// handshake.
//
// Features:
//   - selectable bit order
//   - restart/abort on data_start
//   - back-to-back frames
//   - overflow detection
//   - saturating dropped-frame counter
//
// Parameters
//   DATA_WIDTH  bits per frame (>=2)
//   FIFO_DEPTH  output FIFO entries (power of 2, >=2)
//   MSB_FIRST   1: first received bit ends up in out_data[DATA_WIDTH-1]
//               0: first received bit ends up in out_data[0]
//
// Ports
//   debug_clk    in   sole clock, posedge
//   reset_n      in   asynchronous active-low reset
//   data_start   in   frame start strobe (level, sampled on posedge)
//   sin          in   serial data, one bit per clock while a frame is active
//   out_data     out  FIFO head word (0 while the FIFO is empty)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer takes the head when out_valid & out_ready
//   fifo_level   out  number of words held
//   busy         out  frame in progress
//   overflow     out  1-cycle pulse: completed word dropped (FIFO full)
//   frame_abort  out  1-cycle pulse: partial frame discarded by data_start
//   drop_count   out  saturating count of dropped words
// ---------------------------------------------------------------------------
module debug_frame_receiver #(
    parameter int DATA_WIDTH = 40,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          debug_clk,
    input  logic                          reset_n,
    input  logic                          data_start,
    input  logic                          sin,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_abort,
    output logic [7:0]                    drop_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  last_bit;
    logic                  restart;

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Shift direction decides where the first received bit ends up after
    // DATA_WIDTH shifts.
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], sin};
        end else begin
            shift_next = {sin, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // data_start on the last-bit edge does not abort. It completes the
    // current frame and chains a new one.
    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    assign restart  = (state == ST_SHIFT) && !last_bit && data_start;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = out_ready && !fifo_empty;

    // A pop in the same cycle frees the slot that the completing word takes.
    assign push       = last_bit && (!fifo_full || pop);
    assign drop       = last_bit && fifo_full && !pop;

    assign busy       = (state == ST_SHIFT);
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    // Frame control: state, bit counter and abort pulse.
    always_ff @(posedge debug_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= restart;
            case (state)
                ST_IDLE: begin
                    if (data_start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= data_start ? ST_SHIFT : ST_IDLE;
                    end else if (data_start) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Data path: no reset needed. A restarted frame overwrites all
    // DATA_WIDTH bits before it is written to the FIFO.
    always_ff @(posedge debug_clk) begin
        if (state == ST_SHIFT) begin
            shift_reg <= shift_next;
        end
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= shift_next;
        end
    end

    // FIFO pointers and overflow bookkeeping.
    always_ff @(posedge debug_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_debug_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_debug_frame_receiver
//
// Directed bench for debug_frame_receiver. Two instances share the same
// stimulus:
//   - u_msb: MSB_FIRST=1
//   - u_lsb: MSB_FIRST=0
// Both use DATA_WIDTH=40 and FIFO_DEPTH=4. Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_debug_frame_receiver;

    logic        debug_clk = 1'b0;
    logic        reset_n;
    logic        data_start;
    logic        sin;
    logic        out_ready;

    logic [39:0] out_data_m,    out_data_l;
    logic        out_valid_m,   out_valid_l;
    logic [2:0]  fifo_level_m,  fifo_level_l;
    logic        busy_m,        busy_l;
    logic        overflow_m,    overflow_l;
    logic        frame_abort_m, frame_abort_l;
    logic [7:0]  drop_count_m,  drop_count_l;

    int vectors    = 0;
    int miscompares = 0;

    logic [39:0] words [7];

    always #5 debug_clk = ~debug_clk;

    debug_frame_receiver #(.DATA_WIDTH(40), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .debug_clk  (debug_clk),
        .reset_n    (reset_n),
        .data_start (data_start),
        .sin        (sin),
        .out_data   (out_data_m),
        .out_valid  (out_valid_m),
        .out_ready  (out_ready),
        .fifo_level (fifo_level_m),
        .busy       (busy_m),
        .overflow   (overflow_m),
        .frame_abort(frame_abort_m),
        .drop_count (drop_count_m)
    );

    debug_frame_receiver #(.DATA_WIDTH(40), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .debug_clk  (debug_clk),
        .reset_n    (reset_n),
        .data_start (data_start),
        .sin        (sin),
        .out_data   (out_data_l),
        .out_valid  (out_valid_l),
        .out_ready  (out_ready),
        .fifo_level (fifo_level_l),
        .busy       (busy_l),
        .overflow   (overflow_l),
        .frame_abort(frame_abort_l),
        .drop_count (drop_count_l)
    );

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge debug_clk);
        #1;
    endtask

    task automatic start_tick();
        data_start = 1'b1;
        tick();
        data_start = 1'b0;
    endtask

    // Shift 40 bits, word[39] first. Optionally raise data_start and/or
    // out_ready on the last-bit edge.
    task automatic shift_word(input logic [39:0] word, input logic end_start,
                              input logic pop_last);
        for (int i = 0; i < 40; i++) begin
            sin = word[39-i];
            if (i == 39) begin
                data_start = end_start;
                out_ready  = pop_last;
            end
            tick();
        end
        data_start = 1'b0;
        out_ready  = 1'b0;
        sin        = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        data_start = 1'b0;
        sin        = 1'b0;
        out_ready  = 1'b0;
        repeat (3) tick();
        vectors++; if (out_valid_m !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", out_valid_m); end
        vectors++; if (out_data_m !== 40'h0) begin miscompares++; $display("FAIL rst_data got=%h exp=0", out_data_m); end
        vectors++; if (fifo_level_m !== 3'd0) begin miscompares++; $display("FAIL rst_level got=%0d exp=0", fifo_level_m); end
        vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy_m); end
        vectors++; if ({overflow_m, frame_abort_m} !== 2'b00) begin miscompares++; $display("FAIL rst_pulses got=%b exp=00", {overflow_m, frame_abort_m}); end
        vectors++; if (drop_count_m !== 8'd0) begin miscompares++; $display("FAIL rst_drops got=%0d exp=0", drop_count_m); end
        reset_n = 1'b1;
        // sin toggling while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            sin = i[0];
            tick();
        end
        vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL idle_sin_busy got=%b exp=0", busy_m); end
    endtask

    task automatic test_single_frame();
        logic [39:0] w;
        w = 40'hA9F0AAAAA9;
        start_tick();
        for (int i = 0; i < 39; i++) begin
            sin = w[39-i];
            tick();
        end
        vectors++; if (out_valid_m !== 1'b0) begin miscompares++; $display("FAIL t1_early_valid got=%b exp=0", out_valid_m); end
        vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL t1_busy got=%b exp=1", busy_m); end
        sin = w[0];
        tick();
        vectors++; if (out_valid_m !== 1'b1) begin miscompares++; $display("FAIL t1_valid got=%b exp=1", out_valid_m); end
        vectors++; if (out_data_m !== 40'hA9F0AAAAA9) begin miscompares++; $display("FAIL t1_data got=%h exp=a9f0aaaaa9", out_data_m); end
        vectors++; if (fifo_level_m !== 3'd1) begin miscompares++; $display("FAIL t1_level got=%0d exp=1", fifo_level_m); end
        vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL t1_idle got=%b exp=0", busy_m); end
    endtask

    task automatic test_bit_order();
        vectors++; if (out_data_l !== 40'h9555550F95) begin miscompares++; $display("FAIL t2_lsb_data got=%h exp=9555550f95", out_data_l); end
        // Hold without ready: data stays put.
        tick();
        vectors++; if (out_data_m !== 40'hA9F0AAAAA9) begin miscompares++; $display("FAIL t2_hold got=%h exp=a9f0aaaaa9", out_data_m); end
        out_ready = 1'b1;
        tick();
        vectors++; if (fifo_level_m !== 3'd0) begin miscompares++; $display("FAIL t2_drain got=%0d exp=0", fifo_level_m); end
        vectors++; if (out_data_m !== 40'h0) begin miscompares++; $display("FAIL t2_empty_data got=%h exp=0", out_data_m); end
        // Ready while empty is ignored.
        tick();
        out_ready = 1'b0;
        vectors++; if ({out_valid_m, fifo_level_m} !== 4'b0000) begin miscompares++; $display("FAIL t2_empty_pop got=%b exp=0000", {out_valid_m, fifo_level_m}); end
    endtask

    task automatic test_abort();
        start_tick();
        for (int i = 0; i < 12; i++) begin
            sin = 1'b1;
            tick();
        end
        data_start = 1'b1;
        sin        = 1'b1;
        tick();
        data_start = 1'b0;
        vectors++; if (frame_abort_m !== 1'b1) begin miscompares++; $display("FAIL t3_abort got=%b exp=1", frame_abort_m); end
        vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL t3_busy got=%b exp=1", busy_m); end
        sin = 1'b0;
        tick();
        vectors++; if (frame_abort_m !== 1'b0) begin miscompares++; $display("FAIL t3_abort_1cyc got=%b exp=0", frame_abort_m); end
        // That edge sampled bit 1 (0); 39 more follow.
        for (int i = 1; i < 40; i++) begin
            sin = (i % 3 == 0);
            tick();
        end
        sin = 1'b0;
        // Bits: 0 at index 0, then 1 at every index divisible by 3 (3,6,..,39).
        vectors++; if (fifo_level_m !== 3'd1) begin miscompares++; $display("FAIL t3_level got=%0d exp=1", fifo_level_m); end
        vectors++; if (out_data_m !== 40'h2492492492 >> 1) begin miscompares++; $display("FAIL t3_data got=%h exp=%h", out_data_m, 40'h2492492492 >> 1); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        words[0] = 40'h0102030405;
        words[1] = 40'hF0E1D2C3B4;
        words[2] = 40'h5555AAAA33;
        words[3] = 40'h8000000001;
        words[4] = 40'hDEADBEEF77;
        words[5] = 40'h0;
        words[6] = 40'h13579BDF24;
        start_tick();
        for (int k = 0; k < 5; k++) begin
            shift_word(words[k], (k < 4), 1'b0);
            if (k == 3) begin
                vectors++; if (fifo_level_m !== 3'd4) begin miscompares++; $display("FAIL t4_full_level got=%0d exp=4", fifo_level_m); end
                vectors++; if (overflow_m !== 1'b0) begin miscompares++; $display("FAIL t4_no_ovf got=%b exp=0", overflow_m); end
            end
        end
        vectors++; if (overflow_m !== 1'b1) begin miscompares++; $display("FAIL t4_overflow got=%b exp=1", overflow_m); end
        vectors++; if (drop_count_m !== 8'd1) begin miscompares++; $display("FAIL t4_drops got=%0d exp=1", drop_count_m); end
        vectors++; if (fifo_level_m !== 3'd4) begin miscompares++; $display("FAIL t4_level got=%0d exp=4", fifo_level_m); end
        vectors++; if (out_data_m !== words[0]) begin miscompares++; $display("FAIL t4_head got=%h exp=%h", out_data_m, words[0]); end
        vectors++; if (frame_abort_m !== 1'b0) begin miscompares++; $display("FAIL t4_no_abort got=%b exp=0", frame_abort_m); end
        tick();
        vectors++; if (overflow_m !== 1'b0) begin miscompares++; $display("FAIL t4_ovf_1cyc got=%b exp=0", overflow_m); end
    endtask

    task automatic test_full_push_pop();
        logic [39:0] order [4];
        start_tick();
        shift_word(words[6], 1'b0, 1'b1);
        vectors++; if (overflow_m !== 1'b0) begin miscompares++; $display("FAIL t5_no_ovf got=%b exp=0", overflow_m); end
        vectors++; if (fifo_level_m !== 3'd4) begin miscompares++; $display("FAIL t5_level got=%0d exp=4", fifo_level_m); end
        vectors++; if (drop_count_m !== 8'd1) begin miscompares++; $display("FAIL t5_drops got=%0d exp=1", drop_count_m); end
        order[0] = words[1];
        order[1] = words[2];
        order[2] = words[3];
        order[3] = words[6];
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (out_data_m !== order[k]) begin miscompares++; $display("FAIL t5_order%0d got=%h exp=%h", k, out_data_m, order[k]); end
            tick();
        end
        out_ready = 1'b0;
        vectors++; if (fifo_level_m !== 3'd0) begin miscompares++; $display("FAIL t5_drained got=%0d exp=0", fifo_level_m); end
    endtask

    task automatic test_reset_midframe();
        // Leave one word in the FIFO, then start a frame and reset at bit 20.
        start_tick();
        shift_word(40'h1111111111, 1'b0, 1'b0);
        start_tick();
        for (int i = 0; i < 20; i++) begin
            sin = 1'b1;
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if ({out_valid_m, fifo_level_m, busy_m} !== 5'b0) begin miscompares++; $display("FAIL t6_ctrl got=%b exp=00000", {out_valid_m, fifo_level_m, busy_m}); end
        vectors++; if (out_data_m !== 40'h0) begin miscompares++; $display("FAIL t6_data got=%h exp=0", out_data_m); end
        vectors++; if (drop_count_m !== 8'd0) begin miscompares++; $display("FAIL t6_drops got=%0d exp=0", drop_count_m); end
        vectors++; if ({overflow_m, frame_abort_m} !== 2'b00) begin miscompares++; $display("FAIL t6_pulses got=%b exp=00", {overflow_m, frame_abort_m}); end
        tick();
        reset_n = 1'b1;
        tick();
        vectors++; if ({busy_m, frame_abort_m} !== 2'b00) begin miscompares++; $display("FAIL t6_post_rst got=%b exp=00", {busy_m, frame_abort_m}); end
        start_tick();
        shift_word(40'hC35A0FF081, 1'b0, 1'b0);
        vectors++; if (out_data_m !== 40'hC35A0FF081) begin miscompares++; $display("FAIL t6_clean got=%h exp=c35a0ff081", out_data_m); end
        vectors++; if (fifo_level_m !== 3'd1) begin miscompares++; $display("FAIL t6_level got=%0d exp=1", fifo_level_m); end
        // Bit reversal of c3 5a 0f f0 81 -> 81 0f f0 5a c3.
        vectors++; if (out_data_l !== 40'h810FF05AC3) begin miscompares++; $display("FAIL t6_lsb got=%h exp=810ff05ac3", out_data_l); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_order();
        test_abort();
        test_back_to_back();
        test_full_push_pop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
